// File: rtl/trafficlight_pkg.sv
// Shared light codes, FSM state encoding and index-width helper for the
// multi-approach traffic light controller.
package trafficlight_pkg;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_GREEN  = 2'b01;
  localparam logic [1:0] LT_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_WALK
  } state_e;

  // Direction index width; a single approach still gets a 1-bit index.
  function automatic int dir_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trafficlight_rr_sel.sv
// Round-robin finder: first approach after cur_dir (wrapping) with a latched
// demand; returns cur_dir itself when no other approach is waiting.
module trafficlight_rr_sel
  import trafficlight_pkg::*;
#(
  parameter int  N_DIR = 2,
  localparam int DW    = dir_w(N_DIR)
) (
  input  logic [N_DIR-1:0] dem,
  input  logic [DW-1:0]    cur_dir,
  output logic [DW-1:0]    next_dir,
  output logic             found
);

  localparam logic [DW:0] N_W = (DW+1)'(N_DIR);

  logic [N_DIR-1:0] dem_rot;
  logic [DW:0]      offset;
  logic [DW:0]      sum;

  // dem_rot[k] is the demand of approach (cur_dir + k) mod N_DIR; bit 0 is the
  // current owner and never counts as a candidate.
  assign dem_rot = N_DIR'({dem, dem} >> cur_dir) & ~N_DIR'(1);

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = N_DIR - 1; k >= 0; k--) begin
      if (dem_rot[k]) begin
        offset = (DW+1)'(k);
        found  = 1'b1;
      end
    end
  end

  assign sum      = {1'b0, cur_dir} + offset;
  assign next_dir = !found      ? cur_dir :
                    (sum >= N_W) ? DW'(sum - N_W) : DW'(sum);

endmodule

// File: rtl/trafficlight_multi.sv
// Sensor-actuated N-approach traffic light controller with sticky demands,
// min/max green, yellow and all-red clearance and an optional pedestrian WALK.
module trafficlight_multi
  import trafficlight_pkg::*;
#(
  parameter int  N_DIR       = 2,
  parameter int  CNT_W       = 8,
  parameter int  T_GREEN_MIN = 8,
  parameter int  T_GREEN_MAX = 20,
  parameter int  T_YELLOW    = 3,
  parameter int  T_ALLRED    = 1,
  parameter int  T_WALK      = 6,
  localparam int DW          = dir_w(N_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DIR-1:0]     sensor,
  input  logic                 ped_req,
  output logic [2*N_DIR-1:0]   light,
  output logic                 walk,
  output logic [DW-1:0]        cur_dir,
  output logic [CNT_W-1:0]     phase_cnt
);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);

  state_e             state_q, state_d;
  logic [DW-1:0]      cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_DIR-1:0]   dem_q, dem_d;
  logic               ped_q, ped_d;
  logic [2*N_DIR-1:0] light_q, light_d;
  logic               walk_q, walk_d;

  logic [N_DIR-1:0]   cur_mask;
  logic [N_DIR-1:0]   nxt_mask;
  logic [N_DIR-1:0]   dem_set;
  logic [DW-1:0]      rr_next;
  logic               rr_found;
  logic               other;
  logic               green_exit;
  logic               enter_green;

  function automatic logic [2*N_DIR-1:0] light_of(input state_e s, input logic [DW-1:0] d);
    logic [2*N_DIR-1:0] l;
    l = '0;
    for (int i = 0; i < N_DIR; i++) begin
      if (d == DW'(i)) begin
        if (s == ST_GREEN)       l[2*i +: 2] = LT_GREEN;
        else if (s == ST_YELLOW) l[2*i +: 2] = LT_YELLOW;
        else                     l[2*i +: 2] = LT_RED;
      end
    end
    return l;
  endfunction

  for (genvar gi = 0; gi < N_DIR; gi++) begin : g_mask
    assign cur_mask[gi] = (cur_q == DW'(gi));
    assign nxt_mask[gi] = (cur_d == DW'(gi));
  end

  trafficlight_rr_sel #(
    .N_DIR (N_DIR)
  ) u_rr_sel (
    .dem      (dem_q),
    .cur_dir  (cur_q),
    .next_dir (rr_next),
    .found    (rr_found)
  );

  // The approach currently holding green cannot register demand for itself.
  assign dem_set    = sensor & ~((state_q == ST_GREEN) ? cur_mask : '0);
  assign other      = ped_q | (|(dem_q & ~cur_mask));
  assign green_exit = (cnt_q >= GMIN_LAST) && other &&
                      (!(|(sensor & cur_mask)) || (cnt_q == GMAX_LAST));

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q + 1'b1;
    dem_d       = dem_q | dem_set;
    ped_d       = ped_q | ped_req;
    enter_green = 1'b0;
    case (state_q)
      ST_GREEN: begin
        if (green_exit) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
        end else if (cnt_q == GMAX_LAST) begin
          cnt_d = cnt_q;
        end
      end
      ST_YELLOW: begin
        if (cnt_q == YEL_LAST) begin
          state_d = ST_ALLRED;
          cnt_d   = '0;
        end
      end
      ST_ALLRED: begin
        if (cnt_q == AR_LAST) begin
          if (ped_q) begin
            state_d = ST_WALK;
            cnt_d   = '0;
            ped_d   = 1'b0;
          end else begin
            enter_green = 1'b1;
          end
        end
      end
      ST_WALK: begin
        if (cnt_q == WALK_LAST) enter_green = 1'b1;
      end
      default: begin
        state_d = ST_GREEN;
        cnt_d   = '0;
      end
    endcase
    if (enter_green) begin
      state_d = ST_GREEN;
      cur_d   = rr_found ? rr_next : cur_q;
      cnt_d   = '0;
    end
    // Clearing the served approach's latch overrides a same-cycle set.
    if (enter_green) dem_d = dem_d & ~nxt_mask;
    light_d = light_of(state_d, cur_d);
    walk_d  = (state_d == ST_WALK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GREEN;
      cur_q   <= '0;
      cnt_q   <= '0;
      dem_q   <= '0;
      ped_q   <= 1'b0;
      light_q <= light_of(ST_GREEN, '0);
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      dem_q   <= dem_d;
      ped_q   <= ped_d;
      light_q <= light_d;
      walk_q  <= walk_d;
    end
  end

  assign light     = light_q;
  assign walk      = walk_q;
  assign cur_dir   = cur_q;
  assign phase_cnt = cnt_q;

endmodule

// File: doc/trafficlight_multi.md
Name: trafficlight_multi

Overview:
Parametrised, sensor-actuated controller for N_DIR approaches with an optional all-red pedestrian WALK phase. It generalises the two-light sensor controller in these ways:
- per-direction sticky demand latches;
- minimum and maximum green with extension;
- yellow and all-red clearance intervals;
- round-robin service.

It sits directly behind the tt_um wrapper. Sensors and the pedestrian button come from ui_in; lights and walk drive uo_out.

Parameters:
N_DIR, 2, number of approaches (2..8)
CNT_W, 8, phase timer width
T_GREEN_MIN, 8, minimum green cycles (>=1)
T_GREEN_MAX, 20, maximum green cycles when other demand exists (>=T_GREEN_MIN)
T_YELLOW, 3, yellow cycles (>=1)
T_ALLRED, 1, all-red clearance cycles (>=1)
T_WALK, 6, pedestrian walk cycles (>=1)
All durations must be < 2**CNT_W.

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
sensor  in  N_DIR  vehicle presence per approach, level, synchronous to clk
ped_req  in  1  pedestrian request, level or pulse
light  out  2*N_DIR  per-approach code at [2i+1:2i]: 00 red, 01 green, 10 yellow, 11 unused
walk  out  1  pedestrian walk indication
cur_dir  out  $clog2(N_DIR) (min 1)  approach currently owning green/yellow
phase_cnt  out  CNT_W  elapsed cycles in current phase

Behaviour:
- State machine: GREEN, YELLOW, ALLRED, WALK. All outputs are registered and are a function of state/cur_dir only.
- Reset, checked before anything else:
  - state=GREEN, cur_dir=0, phase_cnt=0;
  - light = approach 0 green, all others red;
  - walk=0; dem[]=0; ped_pend=0.
- phase_cnt:
  - 0 on the first cycle of every phase; +1 per cycle;
  - in GREEN it saturates at T_GREEN_MAX-1.
- Demand latching:
  - dem[i] is set when sensor[i]=1 and NOT (state==GREEN and cur_dir==i).
  - dem[i] is cleared on the edge entering GREEN for approach i; clear wins over a simultaneous set.
  - ped_pend is set on ped_req=1, cleared on the edge entering WALK; clear wins.
- other = OR of dem[j] for j!=cur_dir, OR ped_pend.
- GREEN (light[cur_dir]=01):
  - Exits to YELLOW at the end of the cycle where phase_cnt >= T_GREEN_MIN-1 AND other AND (sensor[cur_dir]==0 OR phase_cnt==T_GREEN_MAX-1).
  - With no other demand, green holds indefinitely.
  - If demand appears after saturation, exit occurs on the next edge, subject to the same rule (max already reached).
- YELLOW (light[cur_dir]=10): lasts exactly T_YELLOW cycles, then ALLRED.
- ALLRED (all lights 00): lasts exactly T_ALLRED cycles. Then WALK if ped_pend, else GREEN on next_dir.
- WALK (all 00, walk=1): lasts exactly T_WALK cycles, then GREEN on next_dir.
- next_dir:
  - first j in order cur_dir+1, cur_dir+2, ... (mod N_DIR, excluding cur_dir) with dem[j]=1;
  - if none, cur_dir is re-served;
  - evaluated on the cycle of transition into GREEN.
- Wrap-around: the search wraps from N_DIR-1 to 0.
- Reset mid-phase: immediate return to the reset state on the next edge. Pending demands are discarded.
- Safety invariant: at most one approach is non-red in any cycle. walk=1 implies all lights red.

Decomposition:
- Package trafficlight_pkg holds:
  - light codes LT_RED/LT_GREEN/LT_YELLOW;
  - state enum (ST_GREEN, ST_YELLOW, ST_ALLRED, ST_WALK);
  - a helper function computing dir-index width.
- Sub-module trafficlight_rr_sel: combinational round-robin finder.
  - Inputs: dem[N_DIR], cur_dir.
  - Outputs: next_dir, found.
  - Instantiated once.
- Timer and FSM stay in the top.

Test Plan:
Bench parameters: N_DIR=2, T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1, T_WALK=3.
1. Reset, no inputs for 50 cycles -> light=2'b_0001 constant, walk=0, phase_cnt climbs to 7 and holds.
2. From reset, sensor[1] pulse 1 cycle at cycle 1, sensor[0]=0 -> dir0 green cycles 0..3, yellow 4..5, all-red 6, dir1 green from cycle 7; dem[1] cleared.
3. sensor[0] held 1, sensor[1] pulsed at cycle 0 -> dir0 green exactly 8 cycles (max), then 2 yellow, 1 all-red, dir1 green.
4. ped_req pulse during dir0 green, no vehicle demand -> after min green: yellow 2, all-red 1, walk=1 for 3 cycles with all lights red, then dir0 green again.
5. N_DIR=4, dem on dirs 1 and 3, cur_dir=3 -> next green is dir1 (wrap), then dir3 only after dir1 yields.
6. reset asserted mid-YELLOW with dem[1]=1 -> next cycle dir0 green, phase_cnt=0, dem cleared; dir1 is not served until its sensor re-asserts.
